// File: rtl/pwm_multi_if.sv
// Control-loop side and gate-drive side of the multi-channel PWM generator.
// The master drives duty, enable and fault controls; the slave returns the gate drives and status.
interface pwm_multi_if #(
  parameter int WIDTH    = 11,
  parameter int CHANNELS = 2
);
  logic                      en;
  logic [CHANNELS*WIDTH-1:0] duty_in;
  logic                      duty_wr;
  logic                      ovr_i;
  logic                      fault_clr;
  logic [CHANNELS-1:0]       pwm_hi;
  logic [CHANNELS-1:0]       pwm_lo;
  logic                      pwm_synch;
  logic                      ovr_i_blank_n;
  logic                      fault;

  modport master (
    output en, duty_in, duty_wr, ovr_i, fault_clr,
    input  pwm_hi, pwm_lo, pwm_synch, ovr_i_blank_n, fault
  );

  modport slave (
    input  en, duty_in, duty_wr, ovr_i, fault_clr,
    output pwm_hi, pwm_lo, pwm_synch, ovr_i_blank_n, fault
  );
endinterface

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared period counter, shadowed per-channel duty, complementary
// outputs with dead time, overcurrent blanking window and latched fault shutdown.
module pwm_multi #(
  parameter int WIDTH    = 11,
  parameter int CHANNELS = 2,
  parameter int DEAD     = 4,
  parameter int BLANK    = 255
) (
  input logic       clk,
  input logic       rst,
  pwm_multi_if.slave bus
);

  localparam int              TW      = (DEAD < 2) ? 1 : $clog2(DEAD + 1);
  localparam logic [TW-1:0]   DEAD_T  = TW'(DEAD);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] BLANK_V = WIDTH'(BLANK);

  logic [WIDTH-1:0]    cnt;
  logic [WIDTH-1:0]    pending [CHANNELS];
  logic [WIDTH-1:0]    active  [CHANNELS];
  logic [CHANNELS-1:0] raw_nxt;
  logic [CHANNELS-1:0] raw_p1;
  logic                synch_p1;
  logic                blank_n_p1;
  logic                fault_q;
  logic                hold_q;
  logic                wrap;
  logic                fault_set;
  logic                fault_rel;
  logic                off;

  assign wrap      = (cnt == CNT_MAX);
  assign fault_set = bus.ovr_i & blank_n_p1;
  assign fault_rel = fault_q & bus.fault_clr & ~bus.ovr_i & ~fault_set;
  // hold_q keeps the bridge off after a fault clear until the next period start
  assign off       = ~bus.en | fault_set | fault_q | hold_q;

  // Stage p0: period counter and duty shadowing
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (!bus.en) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (rst) begin
        pending[i] <= '0;
        active[i]  <= '0;
      end else begin
        if (bus.duty_wr) pending[i] <= bus.duty_in[i*WIDTH +: WIDTH];
        if (!bus.en || wrap) begin
          active[i] <= bus.duty_wr ? bus.duty_in[i*WIDTH +: WIDTH] : pending[i];
        end
      end
    end
  end

  always_comb begin
    raw_nxt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      raw_nxt[i] = ~off & (cnt < active[i]);
    end
  end

  // Stage p1: raw PWM, period sync, blanking window and fault latch
  always_ff @(posedge clk) begin
    if (rst) begin
      raw_p1     <= '0;
      synch_p1   <= 1'b0;
      blank_n_p1 <= 1'b0;
      fault_q    <= 1'b0;
      hold_q     <= 1'b0;
    end else begin
      raw_p1     <= raw_nxt;
      synch_p1   <= bus.en & wrap;
      blank_n_p1 <= bus.en & (cnt > BLANK_V);
      if (fault_set)      fault_q <= 1'b1;
      else if (fault_rel) fault_q <= 1'b0;
      if (fault_set)      hold_q <= 1'b0;
      else if (fault_rel) hold_q <= 1'b1;
      else if (wrap)      hold_q <= 1'b0;
    end
  end

  assign bus.pwm_synch     = synch_p1;
  assign bus.ovr_i_blank_n = blank_n_p1;
  assign bus.fault         = fault_q;

  // Stage p1 (same edge as raw): dead-time insertion, registered alongside raw
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic hi_p1;
    logic lo_p1;

    if (DEAD == 0) begin : g_nodead
      always_ff @(posedge clk) begin
        if (rst) begin
          hi_p1 <= 1'b0;
          lo_p1 <= 1'b0;
        end else begin
          hi_p1 <= raw_nxt[g];
          lo_p1 <= ~off & ~raw_nxt[g];
        end
      end
    end else begin : g_dead
      logic [TW-1:0] tmr;

      // Any forced-off cycle counts as a transition, so restart always goes through dead time
      always_ff @(posedge clk) begin
        if (rst) begin
          tmr   <= DEAD_T;
          hi_p1 <= 1'b0;
          lo_p1 <= 1'b0;
        end else if (off || (raw_nxt[g] != raw_p1[g])) begin
          tmr   <= DEAD_T;
          hi_p1 <= 1'b0;
          lo_p1 <= 1'b0;
        end else if (tmr > TW'(1)) begin
          tmr   <= tmr - 1'b1;
          hi_p1 <= 1'b0;
          lo_p1 <= 1'b0;
        end else begin
          tmr   <= '0;
          hi_p1 <= raw_nxt[g];
          lo_p1 <= ~raw_nxt[g];
        end
      end
    end

    assign bus.pwm_hi[g] = hi_p1;
    assign bus.pwm_lo[g] = lo_p1;
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: two instances (no dead time, 4-cycle dead time) share
// one stimulus stream and are compared every cycle against a period/window reference model.
module tb_pwm_multi;

  localparam int W    = 11;
  localparam int CH   = 2;
  localparam int BL   = 255;
  localparam int PER  = 2048;
  localparam int MAXC = 2047;
  localparam int HD   = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [CH*W-1:0] duty = '0;
  logic          wr = 1'b0;
  logic          ovr = 1'b0;
  logic          fclr = 1'b0;

  always #5 clk = ~clk;

  pwm_multi_if #(.WIDTH(W), .CHANNELS(CH)) if0 ();
  pwm_multi_if #(.WIDTH(W), .CHANNELS(CH)) if4 ();

  assign if0.en = en;  assign if0.duty_in = duty;  assign if0.duty_wr = wr;
  assign if0.ovr_i = ovr;  assign if0.fault_clr = fclr;
  assign if4.en = en;  assign if4.duty_in = duty;  assign if4.duty_wr = wr;
  assign if4.ovr_i = ovr;  assign if4.fault_clr = fclr;

  pwm_multi #(.WIDTH(W), .CHANNELS(CH), .DEAD(0), .BLANK(BL)) u_d0 (.clk(clk), .rst(rst), .bus(if0.slave));
  pwm_multi #(.WIDTH(W), .CHANNELS(CH), .DEAD(4), .BLANK(BL)) u_d4 (.clk(clk), .rst(rst), .bus(if4.slave));

  int total = 0;
  int passes = 0;
  int fails = 0;

  // reference model: period position, per-period duty, fault state, and a raw history window
  int m_cnt = 0;
  int m_pend [CH];
  int m_act  [CH];
  bit m_fault = 0, m_hold = 0, m_synch = 0, m_blank = 0;
  bit h_raw [CH][HD];
  bit h_clean [HD];

  int w_hi0 [CH];
  int w_hi4 [CH];
  int w_lo4 [CH];
  int w_syn = 0;
  int w_on = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // output of a dead-time channel: raw must have held val for dead+1 cycles, the latest dead of them not forced off
  function automatic bit exp_out(int ch, int dead, bit val);
    if (!h_clean[0]) return 1'b0;
    for (int k = 0; k <= dead; k++) if (h_raw[ch][k] != val) return 1'b0;
    for (int k = 0; k < dead; k++) if (!h_clean[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clr_win();
    for (int c = 0; c < CH; c++) begin w_hi0[c] = 0; w_hi4[c] = 0; w_lo4[c] = 0; end
    w_syn = 0;
    w_on = 0;
  endtask

  task automatic step();
    bit set, rel, off, n_clean, n_syn, n_blk, n_flt, n_hold;
    bit n_raw [CH];
    int n_act [CH];
    int n_pend [CH];
    int n_cnt, d;
    logic [CH-1:0] e_hi0, e_lo0, e_hi4, e_lo4;
    if (rst) begin
      for (int c = 0; c < CH; c++) begin n_raw[c] = 0; n_act[c] = 0; n_pend[c] = 0; end
      n_clean = 0; n_syn = 0; n_blk = 0; n_flt = 0; n_hold = 0; n_cnt = 0;
    end else begin
      set = ovr && m_blank;
      rel = m_fault && fclr && !ovr && !set;
      off = !en || set || m_fault || m_hold;
      n_clean = !off;
      n_syn = en && (m_cnt == MAXC);
      n_blk = en && (m_cnt > BL);
      for (int c = 0; c < CH; c++) begin
        d = int'(duty[c*W +: W]);
        n_raw[c] = !off && (m_cnt < m_act[c]);
        n_pend[c] = wr ? d : m_pend[c];
        n_act[c] = (!en || m_cnt == MAXC) ? (wr ? d : m_pend[c]) : m_act[c];
      end
      n_flt = set ? 1'b1 : (rel ? 1'b0 : m_fault);
      n_hold = set ? 1'b0 : (rel ? 1'b1 : ((m_cnt == MAXC) ? 1'b0 : m_hold));
      n_cnt = en ? (m_cnt + 1) % PER : 0;
    end
    @(posedge clk);
    #1;
    for (int k = HD-1; k > 0; k--) begin
      h_clean[k] = h_clean[k-1];
      for (int c = 0; c < CH; c++) h_raw[c][k] = h_raw[c][k-1];
    end
    h_clean[0] = n_clean;
    for (int c = 0; c < CH; c++) begin
      h_raw[c][0] = n_raw[c]; m_act[c] = n_act[c]; m_pend[c] = n_pend[c];
    end
    m_cnt = n_cnt; m_synch = n_syn; m_blank = n_blk; m_fault = n_flt; m_hold = n_hold;
    for (int c = 0; c < CH; c++) begin
      e_hi0[c] = exp_out(c, 0, 1'b1); e_lo0[c] = exp_out(c, 0, 1'b0);
      e_hi4[c] = exp_out(c, 4, 1'b1); e_lo4[c] = exp_out(c, 4, 1'b0);
    end
    chk("cycle_d0", {25'd0, if0.pwm_hi, if0.pwm_lo, if0.pwm_synch, if0.ovr_i_blank_n, if0.fault},
        {25'd0, e_hi0, e_lo0, m_synch, m_blank, m_fault});
    chk("cycle_d4", {25'd0, if4.pwm_hi, if4.pwm_lo, if4.pwm_synch, if4.ovr_i_blank_n, if4.fault},
        {25'd0, e_hi4, e_lo4, m_synch, m_blank, m_fault});
    chk("overlap_d4", {30'd0, if4.pwm_hi & if4.pwm_lo}, 32'd0);
    for (int c = 0; c < CH; c++) begin
      w_hi0[c] += int'(if0.pwm_hi[c]);
      w_hi4[c] += int'(if4.pwm_hi[c]);
      w_lo4[c] += int'(if4.pwm_lo[c]);
    end
    w_syn += int'(if0.pwm_synch);
    w_on += int'(|{if0.pwm_hi, if0.pwm_lo, if4.pwm_hi, if4.pwm_lo});
  endtask

  task automatic run_until(input int t);
    int n = 0;
    while (m_cnt != t && n < 5000) begin step(); n++; end
    if (m_cnt != t) begin
      total++; fails++;
      $error("FAIL timeout: position %0d reached instead of %0d", m_cnt, t);
    end
  endtask

  task automatic set_duty(input int a, input int b);
    duty[0 +: W] = W'(a);
    duty[W +: W] = W'(b);
  endtask

  initial begin
    int r1, r2, oc, wc, n;
    for (int c = 0; c < CH; c++) begin
      m_pend[c] = 0; m_act[c] = 0;
      for (int k = 0; k < HD; k++) h_raw[c][k] = 0;
    end
    for (int k = 0; k < HD; k++) h_clean[k] = 0;

    // reset and load duties 0 / 2047 while disabled
    step(); step();
    chk("rst_cnt", 32'(u_d0.cnt), 32'd0);
    chk("rst_out_d4", {28'd0, if4.pwm_hi, if4.pwm_lo}, 32'd0);
    rst = 1'b0;
    set_duty(0, 2047); wr = 1'b1; step(); wr = 1'b0;
    repeat (5) step();
    chk("en0_cnt", 32'(u_d0.cnt), 32'd0);
    en = 1'b1;
    run_until(0); clr_win(); repeat (PER) step();
    chk("duty0_hi", 32'(w_hi0[0]), 32'd0);
    chk("duty2047_hi", 32'(w_hi0[1]), 32'd2047);
    chk("synch_once", 32'(w_syn), 32'd1);

    // duty 1024 written mid-period, dead-time widths
    run_until(1000); set_duty(1024, 1024); wr = 1'b1; step(); wr = 1'b0;
    run_until(0); clr_win(); repeat (PER) step();
    chk("duty1024_hi", 32'(w_hi0[0]), 32'd1024);
    chk("dead_hi_1024", 32'(w_hi4[0]), 32'd1020);
    chk("dead_lo_1024", 32'(w_lo4[1]), 32'd1020);

    // mid-period write does not touch the running period; write at 2047 applies at once
    r1 = $urandom_range(2040, 5);
    clr_win(); run_until(600); set_duty(512, r1); wr = 1'b1; step(); wr = 1'b0;
    duty = CH*W'($urandom);
    run_until(0);
    chk("midwrite_cur", 32'(w_hi0[0]), 32'd1024);
    clr_win(); r2 = $urandom_range(2040, 5);
    run_until(MAXC); set_duty(3, r2); wr = 1'b1; step(); wr = 1'b0;
    chk("midwrite_next", 32'(w_hi0[0]), 32'd512);
    chk("midwrite_next1", 32'(w_hi0[1]), 32'(r1));
    clr_win(); repeat (PER) step();
    chk("wr2047_ch1", 32'(w_hi0[1]), 32'(r2));
    chk("duty3_hi_d4", 32'(w_hi4[0]), 32'd0);
    chk("duty3_lo_d4", 32'(w_lo4[0]), 32'd2041);

    // random duty writes, ovr pulses inside the blanking window
    for (int p = 0; p < 3; p++) begin
      oc = $urandom_range(200, 1);
      wc = $urandom_range(2040, 300);
      run_until(oc); ovr = 1'b1; step(); ovr = 1'b0;
      run_until(wc); set_duty($urandom_range(2047, 0), $urandom_range(2047, 0));
      wr = 1'b1; step(); wr = 1'b0;
      duty = CH*W'($urandom);
    end
    chk("blanked_no_fault", 32'(if0.fault), 32'd0);

    // fault set, ignored clear, real clear, resume at the next period start
    run_until(10); set_duty(1024, $urandom_range(2040, 5)); wr = 1'b1; step(); wr = 1'b0;
    run_until(0); run_until(100);
    chk("blank_at_100", 32'(if0.ovr_i_blank_n), 32'd0);
    ovr = 1'b1; step(); ovr = 1'b0;
    chk("ovr100_fault", 32'(if0.fault), 32'd0);
    run_until(300);
    chk("blank_at_300", 32'(if0.ovr_i_blank_n), 32'd1);
    ovr = 1'b1; step(); ovr = 1'b0;
    chk("fault_set", 32'(if4.fault), 32'd1);
    chk("fault_outs_off", {24'd0, if0.pwm_hi, if0.pwm_lo, if4.pwm_hi, if4.pwm_lo}, 32'd0);
    step(); fclr = 1'b1; ovr = 1'b1; step(); fclr = 1'b0; ovr = 1'b0;
    chk("clr_with_ovr", 32'(if0.fault), 32'd1);
    run_until(900); fclr = 1'b1; step(); fclr = 1'b0;
    chk("fault_cleared", 32'(if0.fault), 32'd0);
    clr_win(); run_until(0);
    chk("off_until_wrap", 32'(w_on), 32'd0);
    step();
    chk("resume_d0", 32'(if0.pwm_hi[0]), 32'd1);
    chk("resume_d4_gap", 32'(if4.pwm_hi[0]), 32'd0);
    step(); step(); step();
    chk("resume_d4_gap3", 32'(if4.pwm_hi[0]), 32'd0);
    step();
    chk("resume_d4_on", 32'(if4.pwm_hi[0]), 32'd1);

    // reset mid-period, then disable and re-enable
    run_until(1500);
    rst = 1'b1; step(); rst = 1'b0;
    chk("midrst_cnt", 32'(u_d0.cnt), 32'd0);
    chk("midrst_active", 32'(u_d0.active[0]), 32'd0);
    chk("midrst_outs", {24'd0, if0.pwm_hi, if0.pwm_lo, if4.pwm_hi, if4.pwm_lo}, 32'd0);
    clr_win(); repeat (PER) step();
    chk("midrst_duty0", 32'(w_hi0[0] + w_hi0[1]), 32'd0);
    set_duty(700, 1400); wr = 1'b1; step(); wr = 1'b0;
    run_until(1200);
    en = 1'b0; repeat (8) step();
    chk("en0_hold", 32'(u_d0.cnt), 32'd0);
    chk("en0_outs", {24'd0, if0.pwm_hi, if0.pwm_lo, if4.pwm_hi, if4.pwm_lo}, 32'd0);
    en = 1'b1; n = 0;
    step(); n++;
    while (!if0.pwm_synch && n < 3000) begin step(); n++; end
    chk("en1_first_synch", 32'(n), 32'd2048);
    clr_win(); repeat (PER) step();
    chk("en1_duty_ch0", 32'(w_hi0[0]), 32'd700);
    chk("en1_duty_ch1", 32'(w_hi0[1]), 32'd1400);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
Parametrised multi-channel PWM generator, the successor to the single-channel 11-bit PWM. All channels share one free-running period counter. Each channel has its own duty register, shadowed so new values take effect only at a period boundary, and drives a complementary high/low output pair with dead-time insertion. A shared overcurrent blanking window and a latched overcurrent fault shutdown are included. It sits between the motor-drive control loop (duty source) and the power-stage gate drivers.

Parameters:
WIDTH, 11, bit width of period counter and duty values; period = 2^WIDTH clocks
CHANNELS, 2, number of independent PWM channels
DEAD, 4, dead-time in clocks inserted at every output transition (0 = none)
BLANK, 255, counter value at or below which overcurrent sensing is blanked

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
en  input  1  1 = run; 0 = counter held at 0, all outputs low
duty_in  input  CHANNELS*WIDTH  duty for channel i in bits [i*WIDTH +: WIDTH]
duty_wr  input  1  1-cycle strobe: capture duty_in into pending registers
ovr_i  input  1  overcurrent comparator, active-high
fault_clr  input  1  request to clear latched fault
pwm_hi  output  CHANNELS  high-side gate drive per channel
pwm_lo  output  CHANNELS  low-side gate drive per channel
pwm_synch  output  1  1-cycle pulse, last cycle of each period
ovr_i_blank_n  output  1  0 = blanking window active
fault  output  1  latched overcurrent fault

Behaviour:
- Reset (rst=1 at clock edge): cnt=0, pending and active duty=0, raw=0, pwm_hi=pwm_lo=0, dead timers loaded with DEAD, pwm_synch=0, ovr_i_blank_n=0, fault=0. Reset mid-period takes effect on the next edge and aborts the period.
- Counter: with en=1, cnt increments by 1 every clock and wraps 2^WIDTH-1 -> 0. With en=0, cnt is forced to 0.
- Duty shadowing:
  - duty_wr=1 loads all pending registers.
  - Pending is copied to active on the cycle cnt==2^WIDTH-1, or every cycle while en=0.
  - If duty_wr coincides with the copy cycle, the new value goes to active.
  - Mid-period writes never alter the current period.
- Raw PWM: raw_i registered as (cnt < active_i); one clock latency from cnt.
  - High exactly active_i cycles per period.
  - duty=0 gives constant low; duty=2^WIDTH-1 gives low for 1 cycle per period.
  - Forced 0 when en=0 or fault=1.
- Dead time, per channel, on a raw_i change:
  - Both pwm_hi_i and pwm_lo_i go low the next cycle and the timer reloads DEAD.
  - After DEAD consecutive cycles with raw stable, pwm_hi_i=raw_i and pwm_lo_i=~raw_i.
  - A raw change during dead time restarts the timer, so pulses of DEAD cycles or fewer are swallowed.
  - DEAD=0: pwm_hi=raw, pwm_lo=~raw with no gap.
  - pwm_hi_i and pwm_lo_i are never both 1, including across reset, en, and fault transitions.
- After reset, en rising, or fault resume, both outputs stay low for DEAD cycles, then pwm_lo asserts (raw=0 at cnt=0 only if duty=0; otherwise normal dead timing applies).
- pwm_synch: registered (cnt==2^WIDTH-1) AND en, aligned with raw.
- ovr_i_blank_n: registered (cnt > BLANK) AND en.
- Fault:
  - ovr_i is sampled only when ovr_i_blank_n=1.
  - A sampled 1 sets fault the next cycle; raw is forced 0 and pwm_hi/pwm_lo go low the same cycle fault rises, with no dead-time wait on the turn-off.
  - fault clears when fault_clr=1 and ovr_i=0 in the same cycle. fault_clr with ovr_i=1 is ignored.
  - If set and clear conditions occur in the same cycle, set wins.
  - After clear, outputs stay off until the next period start (cnt wraps to 0), then resume through dead timing.
  - The counter keeps running throughout a fault.
- Arithmetic: all compares are unsigned WIDTH-bit. No saturation needed because duty is WIDTH bits.

Test Plan:
- WIDTH=11, DEAD=0; duty ch0=0, ch1=2047, then 1024 -> per 2048-cycle period, raw high for 0, 2047, and 1024 cycles; pwm_synch exactly once per period, aligned with the last raw cycle.
- Active duty 1024, duty_wr with 512 at cnt=600 -> current period high for 1024 cycles, following period high for 512; duty_wr at cnt=2047 takes effect immediately.
- DEAD=4, duty 1024 -> pwm_hi high for 1020 cycles and pwm_lo for 1020 cycles, with 4-cycle both-low gaps at each edge; assert pwm_hi & pwm_lo never 1.
- DEAD=4, duty 3 -> pwm_hi never asserts; pwm_lo low for 7 consecutive cycles per period.
- ovr_i pulse at cnt=100 -> no fault, ovr_i_blank_n=0. ovr_i at cnt=300 -> fault=1 and all outputs 0 the next cycle. fault_clr with ovr_i=1 -> fault stays set. fault_clr with ovr_i=0 at cnt=900 -> fault=0, outputs stay off until cnt wraps, then resume after DEAD cycles.
- rst at cnt=1500 with outputs active -> next cycle: all outputs 0, cnt=0, active duty 0. en=0 -> cnt held at 0, outputs low; en=1 -> counting restarts from 0.
